// File: rtl/ms_timer_pkg.sv
// Shared constants for the ms_timer stopwatch: 7-segment patterns and display masks.
package ms_timer_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned NDIGITS = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // AND mask that lights the decimal point on a full {dp,g..a} byte
    localparam logic [7:0] DP_ON     = 8'h7F;
    localparam logic [7:0] NUM_RESET = 8'hC0;
    localparam logic [3:0] LOC_RESET = 4'b1110;

endpackage

// File: rtl/ms_timer_seg7.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module ms_timer_seg7
    import ms_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ms_timer.sv
// 1 ms stopwatch (0.000-9.999 s) driving a 4-digit multiplexed common-anode display.
module ms_timer
    import ms_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       switch,
    output logic [7:0] num,
    output logic [3:0] loc
);

    localparam int unsigned TW = $clog2(TICK_DIV + 1);
    localparam int unsigned SW = $clog2(SCAN_DIV + 1);

    logic [NDIGITS-1:0][DIGIT_W-1:0] d, d_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [SW-1:0] scan_cnt, scan_nxt;
    logic [1:0]    scan_idx, idx_nxt;
    logic          inc_q;

    logic          tick_wrap, scan_wrap, inc_rise, step, carry;
    logic [SEG_W-1:0] seg_c;
    logic [7:0]    num_nxt;
    logic [3:0]    loc_nxt;

    // Prescaler, step source selection and BCD ripple increment
    always_comb begin
        tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
        inc_rise  = inc & ~inc_q;
        step      = switch ? tick_wrap : inc_rise;

        tick_nxt = tick_cnt;
        if (switch) begin
            tick_nxt = tick_wrap ? '0 : tick_cnt + TW'(1);
        end

        d_nxt = d;
        carry = step;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (carry) begin
                if (d[i] == 4'd9) begin
                    d_nxt[i] = 4'd0;
                end else begin
                    d_nxt[i] = d[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
    end

    // Display scan: num/loc reload together on each digit advance
    always_comb begin
        scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
        scan_nxt  = scan_wrap ? '0 : scan_cnt + SW'(1);
        idx_nxt   = scan_wrap ? scan_idx + 2'd1 : scan_idx;
        loc_nxt   = ~(4'b0001 << idx_nxt);
        num_nxt   = {1'b1, seg_c};
        if (idx_nxt == 2'd3) begin
            num_nxt = num_nxt & DP_ON;
        end
    end

    ms_timer_seg7 u_seg7 (
        .bcd   (d_nxt[idx_nxt]),
        .seg_c (seg_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d        <= '0;
            tick_cnt <= '0;
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            inc_q    <= 1'b0;
            num      <= NUM_RESET;
            loc      <= LOC_RESET;
        end else begin
            d        <= d_nxt;
            tick_cnt <= tick_nxt;
            scan_cnt <= scan_nxt;
            scan_idx <= idx_nxt;
            inc_q    <= inc;
            if (scan_wrap) begin
                num <= num_nxt;
                loc <= loc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ms_timer.sv
// Directed bench for ms_timer with TICK_DIV=2, SCAN_DIV=1 and a 100 ns clock.
module tb_ms_timer;

    logic       clk;
    logic       rst;
    logic       inc;
    logic       switch;
    logic [7:0] num;
    logic [3:0] loc;

    int checks = 0;
    int errors = 0;

    ms_timer #(.TICK_DIV(2), .SCAN_DIV(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .switch (switch),
        .num    (num),
        .loc    (loc)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic int seg2dig(input logic [6:0] s);
        case (s)
            7'h40: return 0;
            7'h79: return 1;
            7'h24: return 2;
            7'h30: return 3;
            7'h19: return 4;
            7'h12: return 5;
            7'h02: return 6;
            7'h78: return 7;
            7'h00: return 8;
            7'h10: return 9;
            default: return 15;
        endcase
    endfunction

    function automatic int loc2idx(input logic [3:0] l);
        case (l)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Reassemble the BCD count from four scanned digits (call while stopped, at a negedge)
    task automatic read_count(output logic [15:0] v);
        int idx;
        v = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            idx = loc2idx(loc);
            if (idx >= 0) v[idx*4 +: 4] = 4'(seg2dig(num[6:0]));
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        #10 rst = 1'b1;
        #10;
        checks++;
        if (loc !== 4'b1110) begin
            errors++; $display("FAIL reset_loc got %b want 1110", loc);
        end
        checks++;
        if (num !== 8'hC0) begin
            errors++; $display("FAIL reset_num got %h want c0", num);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0000) begin
            errors++; $display("FAIL reset_count got %h want 0000", v);
        end
    endtask

    task automatic test_run();
        logic [15:0] v;
        bit found;
        switch = 1'b1;
        repeat (40) @(negedge clk);
        switch = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0020) begin
            errors++; $display("FAIL run_count got %h want 0020", v);
        end
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (loc === 4'b1101) found = 1; else @(negedge clk);
        end
        checks++;
        if (!found || num !== 8'hA4) begin
            errors++; $display("FAIL run_d1 got loc=%b num=%h want loc=1101 num=a4", loc, num);
        end
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (loc === 4'b0111) found = 1; else @(negedge clk);
        end
        checks++;
        if (!found || num !== 8'h40) begin
            errors++; $display("FAIL run_d3_dp got loc=%b num=%h want loc=0111 num=40", loc, num);
        end
    endtask

    task automatic test_stop_inc();
        logic [15:0] v;
        switch = 1'b0;
        inc = 1'b1;
        repeat (4) @(negedge clk);
        inc = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0021) begin
            errors++; $display("FAIL stop_inc got %h want 0021", v);
        end
        repeat (100) @(negedge clk);
        read_count(v);
        checks++;
        if (v !== 16'h0021) begin
            errors++; $display("FAIL stop_hold got %h want 0021", v);
        end
    endtask

    task automatic test_inc_running();
        logic [15:0] v;
        switch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
            @(negedge clk);
        end
        switch = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0024) begin
            errors++; $display("FAIL inc_running got %h want 0024", v);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        switch = 1'b1;
        repeat (19998) @(negedge clk);
        switch = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h9999) begin
            errors++; $display("FAIL wrap_pre got %h want 9999", v);
        end
        switch = 1'b1;
        repeat (2) @(negedge clk);
        switch = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0000) begin
            errors++; $display("FAIL wrap_post got %h want 0000", v);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        logic [3:0] exp_loc [4];
        exp_loc[0] = 4'b1110; exp_loc[1] = 4'b1101;
        exp_loc[2] = 4'b1011; exp_loc[3] = 4'b0111;
        switch = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #20 rst = 1'b1;
        #1;
        checks++;
        if (loc !== 4'b1110 || num !== 8'hC0) begin
            errors++; $display("FAIL async_rst got loc=%b num=%h want loc=1110 num=c0", loc, num);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (loc !== exp_loc[i]) begin
                errors++; $display("FAIL scan_loc%0d got %b want %b", i, loc, exp_loc[i]);
            end
            if (i == 2) switch = 1'b0;
            @(negedge clk);
        end
        read_count(v);
        checks++;
        if (v !== 16'h0001) begin
            errors++; $display("FAIL release_tick got %h want 0001", v);
        end
    endtask

    initial begin
        rst = 1'b0;
        inc = 1'b0;
        switch = 1'b0;
        test_reset();
        test_run();
        test_stop_inc();
        test_inc_running();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
